// File: rtl/jpeg_ff_stuffer_if.sv
// Encoder-side write port and stuffed-word output port
// of the JPEG 0xFF byte stuffer.
interface jpeg_ff_stuffer_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic        last_in;
  logic [2:0]  last_bytes;
  logic [31:0] JPEG_out;
  logic        out_valid;
  logic        out_last;
  logic [2:0]  out_bytes;
  logic        overflow;

  modport master (
    output data_in,
    output data_valid,
    output last_in,
    output last_bytes,
    input  JPEG_out,
    input  out_valid,
    input  out_last,
    input  out_bytes,
    input  overflow
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  last_in,
    input  last_bytes,
    output JPEG_out,
    output out_valid,
    output out_last,
    output out_bytes,
    output overflow
  );
endinterface

// File: rtl/jpeg_ff_stuffer.sv
// JPEG entropy-segment byte stuffer: FIFO, byte walker and
// 32-bit repacker inserting 0x00 after every 0xFF data byte.
module jpeg_ff_stuffer #(
  parameter int FIFO_DEPTH = 16
) (
  input logic               clk,
  input logic               rst,
  jpeg_ff_stuffer_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic        last;
    logic [2:0]  nb;
    logic [31:0] data;
  } ent_t;

  typedef enum logic [1:0] {
    IDLE,
    BYTE,
    FLUSH
  } state_t;

  ent_t        mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] used;
  logic        full, empty;
  logic        wr_en, rd_en;
  ent_t        head;

  state_t      state_q, state_d;
  logic [31:0] sh_q, sh_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [23:0] pk_q, pk_d;
  logic [1:0]  pk_cnt_q, pk_cnt_d;

  logic [31:0] out_word_q, out_word_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [2:0]  out_bytes_q, out_bytes_d;
  logic        ovf_q, ovf_d;

  logic [7:0]  byte_in;
  logic        two;
  logic [39:0] cat;
  logic [2:0]  new_cnt;
  logic        is_final;

  // full has priority over a same-cycle pop
  assign used  = wr_ptr_q - rd_ptr_q;
  assign full  = used[AW];
  assign empty = (used == '0);
  assign wr_en = bus.data_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q[AW-1:0]] <=
        {bus.last_in, bus.last_bytes, bus.data_in};
  end

  // pk_q keeps bytes past its count at zero, so the
  // stuffed 0x00 never needs an explicit write
  always_comb begin
    byte_in = sh_q[31:24];
    two     = (byte_in == 8'hFF);
    cat     = {pk_q, 16'h0};
    unique case (pk_cnt_q)
      2'd0:    cat[39:32] = byte_in;
      2'd1:    cat[31:24] = byte_in;
      2'd2:    cat[23:16] = byte_in;
      default: cat[15:8]  = byte_in;
    endcase
    new_cnt  = {1'b0, pk_cnt_q} + (two ? 3'd2 : 3'd1);
    is_final = ({1'b0, cnt_q} == nbytes_q - 3'd1);
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    pk_d        = pk_q;
    pk_cnt_d    = pk_cnt_q;
    out_word_d  = 32'h0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_bytes_d = 3'd0;
    rd_en       = 1'b0;
    ovf_d       = ovf_q | (bus.data_valid & full);

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          rd_en  = 1'b1;
          sh_d   = head.data;
          last_d = head.last;
          cnt_d  = 2'd0;
          if (head.last && head.nb != 3'd0
              && head.nb <= 3'd4)
            nbytes_d = head.nb;
          else
            nbytes_d = 3'd4;
          state_d = BYTE;
        end
      end

      BYTE: begin
        sh_d  = sh_q << 8;
        cnt_d = cnt_q + 2'd1;
        if (new_cnt[2]) begin
          out_valid_d = 1'b1;
          out_word_d  = cat[39:8];
          out_bytes_d = 3'd4;
          out_last_d  = is_final && last_q
                        && !new_cnt[0];
          pk_d        = {cat[7:0], 16'h0};
          pk_cnt_d    = {1'b0, new_cnt[0]};
        end else if (is_final && last_q) begin
          out_valid_d = 1'b1;
          out_word_d  = cat[39:8];
          out_bytes_d = new_cnt;
          out_last_d  = 1'b1;
          pk_d        = 24'h0;
          pk_cnt_d    = 2'd0;
        end else begin
          pk_d     = cat[39:16];
          pk_cnt_d = new_cnt[1:0];
        end
        if (is_final) begin
          if (last_q && new_cnt == 3'd5)
            state_d = FLUSH;
          else
            state_d = IDLE;
        end
      end

      FLUSH: begin
        out_valid_d = 1'b1;
        out_word_d  = {pk_q[23:16], 24'h0};
        out_bytes_d = 3'd1;
        out_last_d  = 1'b1;
        pk_d        = 24'h0;
        pk_cnt_d    = 2'd0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      sh_q        <= 32'h0;
      nbytes_q    <= 3'd0;
      cnt_q       <= 2'd0;
      last_q      <= 1'b0;
      pk_q        <= 24'h0;
      pk_cnt_q    <= 2'd0;
      out_word_q  <= 32'h0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bytes_q <= 3'd0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      sh_q        <= sh_d;
      nbytes_q    <= nbytes_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      pk_q        <= pk_d;
      pk_cnt_q    <= pk_cnt_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_bytes_q <= out_bytes_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.JPEG_out  = out_word_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_bytes = out_bytes_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_jpeg_ff_stuffer.sv
// Bench for jpeg_ff_stuffer: directed table, corner sequences
// and random words against a byte-queue reference model.
module tb_jpeg_ff_stuffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jpeg_ff_stuffer_if bus();

  jpeg_ff_stuffer #(.FIFO_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] w;
    logic        l;
    logic [2:0]  b;
    longint      c;
  } ow_t;

  typedef struct {
    int          nin;
    logic [31:0] d  [2];
    logic        l  [2];
    logic [2:0]  lb [2];
    int          nexp;
    logic [31:0] ew [3];
    logic        el [3];
    logic [2:0]  eb [3];
    bit          consec;
  } case_t;

  int     n_chk = 0;
  int     n_pass = 0;
  longint cyc = 0;
  ow_t    got[$];
  ow_t    expq[$];
  logic [7:0] mq[$];
  case_t  tc[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, req);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1)
      got.push_back('{bus.JPEG_out, bus.out_last,
                      bus.out_bytes, cyc});
    else if (rst === 1'b0)
      chk("idle_zero",
          64'({bus.JPEG_out, bus.out_last,
               bus.out_bytes}), 64'h0);
  end

  task automatic wr(input logic [31:0] d,
                    input logic l,
                    input logic [2:0] lb);
    bus.data_in    = d;
    bus.last_in    = l;
    bus.last_bytes = lb;
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    bus.last_in    = 1'b0;
    bus.last_bytes = 3'd0;
    bus.data_in    = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stuffed byte stream chopped into 4-byte words;
  // a scan end flushes the remainder as the last word.
  task automatic model(input logic [31:0] d,
                       input logic l,
                       input logic [2:0] lb);
    int nb;
    logic [7:0] b;
    ow_t o;
    nb = (l && lb >= 1 && lb <= 4) ? int'(lb) : 4;
    for (int i = 0; i < nb; i++) begin
      b = d[31-8*i -: 8];
      mq.push_back(b);
      if (b == 8'hFF) mq.push_back(8'h00);
    end
    while (mq.size() >= 4) begin
      o.w = {mq[0], mq[1], mq[2], mq[3]};
      o.l = l && (mq.size() == 4);
      o.b = 3'd4;
      o.c = 0;
      repeat (4) void'(mq.pop_front());
      expq.push_back(o);
    end
    if (l && mq.size() > 0) begin
      o.w = 32'h0;
      for (int i = 0; i < mq.size(); i++)
        o.w[31-8*i -: 8] = mq[i];
      o.l = 1'b1;
      o.b = 3'(mq.size());
      o.c = 0;
      mq.delete();
      expq.push_back(o);
    end
  endtask

  task automatic compare(input string nm);
    chk({nm, "_count"}, 64'(got.size()),
        64'(expq.size()));
    for (int i = 0; i < expq.size()
         && i < got.size(); i++)
      chk(nm,
          64'({got[i].w, got[i].l, got[i].b}),
          64'({expq[i].w, expq[i].l, expq[i].b}));
    got.delete();
    expq.delete();
  endtask

  initial begin
    logic [31:0] base, step, w;
    logic [7:0]  bt;
    logic        ok, l;
    int          idx, prev;

    tc[0] = '{2, '{32'h12345678, 32'h9ABCDEF0},
              '{1'b0, 1'b1}, '{3'd0, 3'd4}, 2,
              '{32'h12345678, 32'h9ABCDEF0, 32'h0},
              '{1'b0, 1'b1, 1'b0},
              '{3'd4, 3'd4, 3'd0}, 1'b0};
    tc[1] = '{2, '{32'hFFFFFFFF, 32'h11223344},
              '{1'b0, 1'b1}, '{3'd0, 3'd4}, 3,
              '{32'hFF00FF00, 32'hFF00FF00,
                32'h11223344},
              '{1'b0, 1'b0, 1'b1},
              '{3'd4, 3'd4, 3'd4}, 1'b0};
    tc[2] = '{1, '{32'hABFF1234, 32'h0},
              '{1'b1, 1'b0}, '{3'd2, 3'd0}, 1,
              '{32'hABFF0000, 32'h0, 32'h0},
              '{1'b1, 1'b0, 1'b0},
              '{3'd3, 3'd0, 3'd0}, 1'b0};
    tc[3] = '{1, '{32'h112233FF, 32'h0},
              '{1'b1, 1'b0}, '{3'd4, 3'd0}, 2,
              '{32'h112233FF, 32'h0, 32'h0},
              '{1'b0, 1'b1, 1'b0},
              '{3'd4, 3'd1, 3'd0}, 1'b1};
    tc[4] = '{1, '{32'hA1B2C3D4, 32'h0},
              '{1'b1, 1'b0}, '{3'd0, 3'd0}, 1,
              '{32'hA1B2C3D4, 32'h0, 32'h0},
              '{1'b1, 1'b0, 1'b0},
              '{3'd4, 3'd0, 3'd0}, 1'b0};
    tc[5] = '{1, '{32'hFF123456, 32'h0},
              '{1'b1, 1'b0}, '{3'd1, 3'd0}, 1,
              '{32'hFF000000, 32'h0, 32'h0},
              '{1'b1, 1'b0, 1'b0},
              '{3'd2, 3'd0, 3'd0}, 1'b0};

    bus.data_in    = 32'h0;
    bus.data_valid = 1'b0;
    bus.last_in    = 1'b0;
    bus.last_bytes = 3'd0;
    rst = 1'b1;
    idle(3);
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_word", 64'(bus.JPEG_out), 64'h0);
    chk("rst_lastbytes",
        64'({bus.out_last, bus.out_bytes}), 64'h0);
    chk("rst_overflow", 64'(bus.overflow), 64'h0);
    rst = 1'b0;
    idle(2);

    for (int t = 0; t < 6; t++) begin
      got.delete();
      for (int i = 0; i < tc[t].nin; i++)
        wr(tc[t].d[i], tc[t].l[i], tc[t].lb[i]);
      idle(30);
      chk($sformatf("tc%0d_count", t),
          64'(got.size()), 64'(tc[t].nexp));
      for (int j = 0; j < tc[t].nexp
           && j < got.size(); j++)
        chk($sformatf("tc%0d_word%0d", t, j),
            64'({got[j].w, got[j].l, got[j].b}),
            64'({tc[t].ew[j], tc[t].el[j],
                 tc[t].eb[j]}));
      if (tc[t].consec && got.size() >= 2)
        chk($sformatf("tc%0d_consec", t),
            64'(got[1].c - got[0].c), 64'd1);
    end
    got.delete();

    // random scans, paced so the FIFO never fills
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 4; k++) begin
        bt = ($urandom_range(0, 9) < 3)
             ? 8'hFF : 8'($urandom);
        w[31-8*k -: 8] = bt;
      end
      l  = (n == 59) || ($urandom_range(0, 3) == 0);
      bt = 8'($urandom_range(0, 7));
      model(w, l, bt[2:0]);
      wr(w, l, bt[2:0]);
      idle($urandom_range(5, 10));
    end
    idle(40);
    compare("rand");
    chk("rand_no_overflow", 64'(bus.overflow), 64'h0);

    // overflow burst: survivors must be an ordered,
    // uncorrupted subsequence starting with 16 in a row
    base = 32'h01020304;
    step = 32'h01010101;
    got.delete();
    for (int i = 0; i < 32; i++)
      wr(base + step * 32'(i), i == 31,
         (i == 31) ? 3'd4 : 3'd0);
    idle(300);
    chk("ovf_flag", 64'(bus.overflow), 64'h1);
    ok = (got.size() >= 17) && (got.size() <= 31);
    chk("ovf_count_range", 64'(ok), 64'h1);
    prev = -1;
    for (int k = 0; k < got.size(); k++) begin
      idx = int'((got[k].w - base) / step);
      ok  = (base + step * 32'(idx) == got[k].w)
            && (idx > prev) && (idx < 32)
            && (k >= 16 || idx == k)
            && (got[k].b == 3'd4);
      chk($sformatf("ovf_word%0d", k),
          64'(ok), 64'h1);
      prev = idx;
    end

    // reset while BYTE runs with entries pending
    got.delete();
    wr(32'h01234567, 1'b0, 3'd0);
    wr(32'h89ABCDEF, 1'b0, 3'd0);
    wr(32'h02468ACE, 1'b0, 3'd0);
    wr(32'h13579BDF, 1'b0, 3'd0);
    #2 rst = 1'b1;
    #1;
    chk("amid_overflow", 64'(bus.overflow), 64'h0);
    chk("amid_valid", 64'(bus.out_valid), 64'h0);
    chk("amid_word", 64'(bus.JPEG_out), 64'h0);
    chk("amid_lastbytes",
        64'({bus.out_last, bus.out_bytes}), 64'h0);
    idle(2);
    got.delete();
    rst = 1'b0;
    idle(2);
    wr(32'hCAFEBABE, 1'b1, 3'd4);
    idle(20);
    chk("post_rst_count", 64'(got.size()), 64'd1);
    if (got.size() >= 1)
      chk("post_rst_word",
          64'({got[0].w, got[0].l, got[0].b}),
          64'({32'hCAFEBABE, 1'b1, 3'd4}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jpeg_ff_stuffer.md
# jpeg_ff_stuffer

Byte-stuffing stage that sits directly downstream of a component encoder (Y/Cb/Cr DCT→quantizer→Huffman chain). It consumes the encoder's 32-bit Huffman bitstream words and inserts a 0x00 byte after every 0xFF data byte, as JPEG entropy-coded segments require. It repacks the stuffed byte stream into MSB-aligned 32-bit output words. An input FIFO absorbs the bursty encoder output because the encoder has no backpressure.

## Interface
- FIFO_DEPTH, 16, input FIFO entries (power of two, ≥4)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- data_in  in  32  Huffman bitstream word, MSB = first byte
- data_valid  in  1  write strobe for data_in (encoder data_ready)
- last_in  in  1  qualifies data_valid: final word of the scan
- last_bytes  in  3  valid bytes in final word (1–4, MSB-aligned); ignored when last_in=0
- JPEG_out  out  32  stuffed output word, MSB-aligned, unused bytes zero
- out_valid  out  1  one-cycle strobe, JPEG_out valid
- out_last  out  1  with out_valid: word carries the final byte of the scan
- out_bytes  out  3  with out_valid: valid bytes (4 unless out_last)
- overflow  out  1  sticky: a write was dropped because the FIFO was full

## Operation
- Reset is asynchronous and active-high: rst clears the FIFO, the state machine, the packer and overflow. All outputs reset to 0.
- FIFO entry is {last_in, last_bytes, data_in}, 36 bits.
- A write happens when data_valid=1 and the FIFO is not full.
- A write with the FIFO full is dropped and sets overflow=1. Only rst clears overflow.
- A write and a pop in the same cycle with the FIFO full: the write is dropped. Full is evaluated before the pop.
- A write and a pop in the same cycle with the FIFO empty: the pop does not see the new entry.
- State machine states are IDLE, BYTE, FLUSH.
- IDLE: if the FIFO is not empty, pop one entry into the shift register and set nbytes. nbytes is last_bytes if last, else 4. Go to BYTE with byte counter 0.
- BYTE: process the top byte of the shift register each cycle.
  - Push the byte into the packer. If the byte is 0xFF, also push 0x00 in the same cycle (two-byte push).
  - Shift left by 8 and increment the counter.
  - When counter = nbytes−1:
    - not last: go to IDLE.
    - last and bytes remain in the packer after this cycle's emission: go to FLUSH.
    - otherwise: go to IDLE.
- Packer holds 0–3 bytes plus a fill count.
  - If a push brings the count to 4 or more, emit a word of the first four bytes.
  - One leftover byte is possible: count 3 followed by a two-byte push leaves the 0x00.
- Last-byte emission, at the final byte of a last entry:
  - If the packer count after the push is exactly 4: emit with out_last=1, out_bytes=4, and go to IDLE.
  - If the count is 1–3: emit the partial word immediately with out_last=1, out_bytes=count, zero-padded low bytes, and clear the packer.
  - If the count is 5: emit the full word with out_last=0, then go to FLUSH.
- FLUSH: emit the leftover byte as JPEG_out={byte,24'h0} with out_last=1, out_bytes=1. Clear the packer and go to IDLE.
- A last entry with last_bytes outside 1–4 is treated as 4.
- After a last entry the packer is always empty, so the next scan starts byte-aligned.

## Timing
- Outputs are registered. out_valid rises the cycle after the BYTE (or FLUSH) cycle that completes the word.
- Latency is 1 cycle from write to visibility in the FIFO.
  - Write at cycle t with the FIFO empty and the state machine in IDLE: pop at t+1, first BYTE at t+2.
  - The earliest output is at t+5 (4 BYTE cycles, then the register stage).
- Throughput is one entry per nbytes+1 cycles. IDLE is a one-cycle bubble. FLUSH adds one cycle.
- At most one out_valid per cycle.
- out_last, out_bytes and JPEG_out are 0 whenever out_valid=0.

## Test plan
- Plain data:
  - Stimulus: 0x12345678 (not last), then 0x9ABCDEF0 last, last_bytes=4.
  - Required: two words 0x12345678 (out_bytes=4), then 0x9ABCDEF0 (out_last=1, out_bytes=4).
  - Required: no extra out_valid after them.
- All-FF:
  - Stimulus: 0xFFFFFFFF, then 0x11223344 last, last_bytes=4.
  - Required outputs, in order: 0xFF00FF00, 0xFF00FF00, 0x11223344 (last, 4).
- Partial last with FF:
  - Stimulus: 0xABFF1234 last, last_bytes=2.
  - Required: one word 0xABFF0000 with out_last=1, out_bytes=3.
- FLUSH path:
  - Stimulus: 0x112233FF last, last_bytes=4.
  - Required: 0x112233FF (out_last=0, out_bytes=4).
  - Required next: 0x00000000 (out_last=1, out_bytes=1), on the following cycle.
- Overflow:
  - Stimulus: 32 back-to-back data_valid words with distinct values, the last one last_bytes=4.
  - Required: overflow=1.
  - Required: the output is exactly the accepted words, in order, unstuffed-equal, with no corruption.
- Reset mid-operation:
  - Stimulus: assert rst during BYTE with 3 FIFO entries pending.
  - Required: all outputs and overflow are 0 immediately (asynchronous).
  - Required: after release, 0xCAFEBABE last, last_bytes=4 emits exactly 0xCAFEBABE (last, 4).
